// File: rtl/axi1_sram_slave.sv
// AXI v1.0 slave endpoint backed by a word-addressed register array.
// Independent write (AW/W/B) and read (AR/R) FSMs, each holding one outstanding burst.
module axi1_sram_slave #(
    parameter int unsigned NUM_DATA_BITS   = 32,
    parameter int unsigned NUM_ADDR_BITS_P = 32,
    parameter int unsigned NUM_ID_BITS_P   = 4,
    parameter int unsigned MEM_WORDS_LOG2  = 8
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_ID_BITS_P-1:0]     awid,
    input  logic [NUM_ADDR_BITS_P-1:0]   awaddr,
    input  logic [3:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [NUM_ID_BITS_P-1:0]     wid,
    input  logic [NUM_DATA_BITS-1:0]     wdata,
    input  logic [NUM_DATA_BITS/8-1:0]   wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [NUM_ID_BITS_P-1:0]     bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [NUM_ID_BITS_P-1:0]     arid,
    input  logic [NUM_ADDR_BITS_P-1:0]   araddr,
    input  logic [3:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [NUM_ID_BITS_P-1:0]     rid,
    output logic [NUM_DATA_BITS-1:0]     rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready
);

    localparam int unsigned DW    = NUM_DATA_BITS;
    localparam int unsigned AW    = NUM_ADDR_BITS_P;
    localparam int unsigned IW    = NUM_ID_BITS_P;
    localparam int unsigned SW    = NUM_DATA_BITS / 8;
    localparam int unsigned LSB   = $clog2(SW);
    localparam int unsigned MW    = MEM_WORDS_LOG2;
    localparam int unsigned DEPTH = 2 ** MEM_WORDS_LOG2;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Address of the beat following addr; WRAP folds back inside the (len+1)*B window.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                                 input logic [AW-1:0] start,
                                                 input logic [3:0]    len,
                                                 input logic [2:0]    size,
                                                 input logic [1:0]    burst);
        logic [AW-1:0] step;
        logic [AW-1:0] mask;
        step = AW'(1) << size;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        if (burst == 2'b00)
            return addr;
        else if (burst == 2'b10)
            return (start & ~mask) | ((addr + step) & mask);
        else
            return addr + step;
    endfunction

    function automatic logic burst_err(input logic [AW-1:0] start,
                                       input logic [3:0]    len,
                                       input logic [2:0]    size,
                                       input logic [1:0]    burst);
        logic err;
        err = (size > 3'(LSB)) || (burst == 2'b11);
        if (burst == 2'b10) begin
            if (!(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) err = 1'b1;
            if ((start & ((AW'(1) << size) - AW'(1))) != '0) err = 1'b1;
        end
        return err;
    endfunction

    logic [DW-1:0] mem_q [DEPTH];

    w_state_e        w_state_q, w_state_d;
    logic [IW-1:0]   aw_id_q, aw_id_d;
    logic [AW-1:0]   aw_addr_q, aw_addr_d, aw_start_q, aw_start_d;
    logic [3:0]      aw_len_q, aw_len_d;
    logic [2:0]      aw_size_q, aw_size_d;
    logic [1:0]      aw_burst_q, aw_burst_d;
    logic [4:0]      w_beat_q, w_beat_d;
    logic            w_err_q, w_err_d;
    logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            mem_we_c;
    logic [MW-1:0]   w_idx_c;

    r_state_e        r_state_q, r_state_d;
    logic [IW-1:0]   ar_id_q, ar_id_d;
    logic [AW-1:0]   ar_addr_q, ar_addr_d, ar_start_q, ar_start_d;
    logic [3:0]      ar_len_q, ar_len_d;
    logic [2:0]      ar_size_q, ar_size_d;
    logic [1:0]      ar_burst_q, ar_burst_d;
    logic [3:0]      r_beat_q, r_beat_d;
    logic            r_err_q, r_err_d;
    logic            arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [MW-1:0]   r_idx_c;

    logic            unused_wid;

    assign unused_wid = ^wid;
    assign w_idx_c    = aw_addr_q[MW+LSB-1:LSB];
    assign r_idx_c    = ar_addr_q[MW+LSB-1:LSB];

    // Write FSM: next state, capture and registered-output values.
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_start_d = aw_start_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_beat_d   = w_beat_q;
        w_err_d    = w_err_q;
        mem_we_c   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_id_d    = awid;
                    aw_addr_d  = awaddr;
                    aw_start_d = awaddr;
                    aw_len_d   = awlen;
                    aw_size_d  = awsize;
                    aw_burst_d = awburst;
                    w_beat_d   = '0;
                    w_err_d    = burst_err(awaddr, awlen, awsize, awburst);
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    if (w_beat_q <= 5'(aw_len_q)) mem_we_c = 1'b1;
                    else                          w_err_d  = 1'b1;
                    if (w_beat_q != 5'd31) w_beat_d = w_beat_q + 5'd1;
                    aw_addr_d = next_addr(aw_addr_q, aw_start_q, aw_len_q, aw_size_q, aw_burst_q);
                    if (wlast) begin
                        if (w_beat_q != 5'(aw_len_q)) w_err_d = 1'b1;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = (w_state_d == W_RESP && w_err_d) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_start_q <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_beat_q   <= '0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_start_q <= aw_start_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_beat_q   <= w_beat_d;
            w_err_q    <= w_err_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Array contents survive reset, so this block has no reset branch.
    always_ff @(posedge aclk) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(SW); i++) begin
                if (wstrb[i]) mem_q[w_idx_c][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read FSM: next state, capture and registered-output values.
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_start_d = ar_start_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_beat_d   = r_beat_q;
        r_err_d    = r_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    ar_id_d    = arid;
                    ar_addr_d  = araddr;
                    ar_start_d = araddr;
                    ar_len_d   = arlen;
                    ar_size_d  = arsize;
                    ar_burst_d = arburst;
                    r_beat_d   = '0;
                    r_err_d    = burst_err(araddr, arlen, arsize, arburst);
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    ar_addr_d = next_addr(ar_addr_q, ar_start_q, ar_len_q, ar_size_q, ar_burst_q);
                    r_beat_d  = r_beat_q + 4'd1;
                    if (rlast_q) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = (r_state_d == R_DATA) && (r_beat_d == ar_len_d);
        rresp_d   = (r_state_d == R_DATA && r_err_d) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_start_q <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_beat_q   <= '0;
            r_err_q    <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_start_q <= ar_start_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_beat_q   <= r_beat_d;
            r_err_q    <= r_err_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = aw_id_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = ar_id_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    // Read is combinational from the registered beat address; zero while idle.
    assign rdata   = rvalid_q ? mem_q[r_idx_c] : '0;

endmodule

// File: tb/tb_axi1_sram_slave.sv
// Randomized bench for axi1_sram_slave with a byte-level array model and
// burst address sequences computed directly from the addressing rules.
module tb_axi1_sram_slave;

    logic        aclk, areset;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [3:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic awvalid, awready;
    logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb; logic wlast, wvalid, wready;
    logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid, bready;
    logic [3:0]  arid;   logic [31:0] araddr; logic [3:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic arvalid, arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp; logic rlast, rvalid, rready;

    axi1_sram_slave #(
        .NUM_DATA_BITS(32), .NUM_ADDR_BITS_P(32), .NUM_ID_BITS_P(4), .MEM_WORDS_LOG2(8)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem_m [256];
    logic [31:0] wbuf  [32];
    logic [3:0]  sbuf  [32];
    logic [31:0] rd_q  [$];
    logic [1:0]  last_bresp;
    logic [1:0]  last_rresp;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int k);
        logic [31:0] b, total, base;
        b     = 32'd1 << size;
        total = 32'(len + 1) * b;
        base  = start - (start % total);
        case (burst)
            0:       return start;
            2:       return base + ((start + 32'(k) * b) % total);
            default: return start + 32'(k) * b;
        endcase
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    function automatic bit exp_err(input logic [31:0] start, input int len, input int size,
                                   input int burst);
        bit e;
        e = (size > 2) || (burst == 3);
        if (burst == 2) begin
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
            if ((start % (32'd1 << size)) != 0) e = 1'b1;
        end
        return e;
    endfunction

    // Called and returns just after a falling edge; nbeats W beats, wlast on the final one.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int nbeats, input int bp);
        int cyc, idx;
        bit e;
        e = exp_err(addr, len, size, burst) || (nbeats != len + 1);
        awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        cyc = 0;
        while (awready !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
        check_val("aw_accept", 64'(awready), 64'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            wvalid = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge aclk);
            wvalid = 1'b1; wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == nbeats - 1);
            wid = 4'($urandom);
            cyc = 0;
            while (wready !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
            check_val("w_accept", 64'(wready), 64'd1);
            if (k <= len) begin
                idx = word_idx(beat_addr(addr, len, size, burst, k));
                for (int b = 0; b < 4; b++)
                    if (sbuf[k][b]) mem_m[idx][8*b +: 8] = wbuf[k][8*b +: 8];
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        last_bresp = bresp;
        check_val("bvalid", 64'(bvalid), 64'd1);
        check_val("bid", 64'(bid), 64'(id));
        check_val("bresp", 64'(bresp), e ? 64'd2 : 64'd0);
        check_val("awready_busy", 64'(awready), 64'd0);
        repeat (bp) begin
            @(negedge aclk);
            check_val("bvalid_hold", 64'(bvalid), 64'd1);
            check_val("bid_hold", 64'(bid), 64'(id));
            check_val("awready_hold", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check_val("bvalid_drop", 64'(bvalid), 64'd0);
        check_val("awready_back", 64'(awready), 64'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst);
        int cyc, k;
        bit e;
        bit hs;
        logic [31:0] ex;
        e = exp_err(addr, len, size, burst);
        rd_q.delete();
        arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        cyc = 0;
        while (arready !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
        check_val("ar_accept", 64'(arready), 64'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        check_val("arready_busy", 64'(arready), 64'd0);
        k = 0; cyc = 0;
        while (k <= len && cyc < 200) begin
            ex = mem_m[word_idx(beat_addr(addr, len, size, burst, k))];
            check_val("rvalid", 64'(rvalid), 64'd1);
            check_val("rdata", 64'(rdata), 64'(ex));
            check_val("rlast", 64'(rlast), 64'(k == len));
            check_val("rresp", 64'(rresp), e ? 64'd2 : 64'd0);
            check_val("rid", 64'(rid), 64'(id));
            last_rresp = rresp;
            hs = ($urandom_range(0, 2) != 0);
            rready = hs;
            if (hs) rd_q.push_back(rdata);
            @(negedge aclk);
            cyc++;
            if (hs) k++;
        end
        rready = 1'b0;
        check_val("r_beats", 64'(k), 64'(len + 1));
        check_val("rvalid_drop", 64'(rvalid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_v [4];
        int len, size, burst, nb, r;
        logic [31:0] addr;

        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge aclk);
        check_val("rst_awready", 64'(awready), 64'd0);
        check_val("rst_arready", 64'(arready), 64'd0);
        check_val("rst_wready", 64'(wready), 64'd0);
        check_val("rst_bvalid", 64'(bvalid), 64'd0);
        check_val("rst_rvalid", 64'(rvalid), 64'd0);
        check_val("rst_rdata", 64'(rdata), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check_val("rel_awready", 64'(awready), 64'd1);
        check_val("rel_arready", 64'(arready), 64'd1);
        check_val("rel_wready", 64'(wready), 64'd0);

        // Reset in the middle of a write burst.
        awid = 4'd3; awaddr = 32'h0; awlen = 4'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wstrb = 4'hF; wdata = 32'h1111_1111;
        @(negedge aclk);
        wdata = 32'h2222_2222;
        @(negedge aclk);
        check_val("mid_wready", 64'(wready), 64'd1);
        #2 areset = 1'b1;
        #1;
        check_val("mid_rst_awready", 64'(awready), 64'd0);
        check_val("mid_rst_wready", 64'(wready), 64'd0);
        check_val("mid_rst_bvalid", 64'(bvalid), 64'd0);
        check_val("mid_rst_arready", 64'(arready), 64'd0);
        check_val("mid_rst_rvalid", 64'(rvalid), 64'd0);
        wvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check_val("post_rst_awready", 64'(awready), 64'd1);
        check_val("post_rst_arready", 64'(arready), 64'd1);
        repeat (4) begin
            @(negedge aclk);
            check_val("post_rst_no_b", 64'(bvalid), 64'd0);
        end

        // Fill the whole array so every later read has a known expectation.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
            do_write(4'(i), 32'(i * 64), 15, 2, 1, 16, 0);
        end

        // INCR write and read-back.
        for (int k = 0; k < 4; k++) begin wbuf[k] = 32'hA0 + 32'(k); sbuf[k] = 4'hF; end
        do_write(4'd5, 32'h10, 3, 2, 1, 4, 0);
        do_read(4'd9, 32'h10, 3, 2, 1);
        check_val("incr_count", 64'(rd_q.size()), 64'd4);
        for (int i = 0; i < rd_q.size() && i < 4; i++)
            check_val("incr_data", 64'(rd_q[i]), 64'h0A0 + 64'(i));

        // WRAP read over a 4-word window starting mid-window.
        for (int k = 0; k < 4; k++) begin wbuf[k] = 32'(k); sbuf[k] = 4'hF; end
        do_write(4'd1, 32'h0, 3, 2, 1, 4, 0);
        do_read(4'd2, 32'h8, 3, 2, 2);
        exp_v[0] = 32'd2; exp_v[1] = 32'd3; exp_v[2] = 32'd0; exp_v[3] = 32'd1;
        check_val("wrap_count", 64'(rd_q.size()), 64'd4);
        for (int i = 0; i < rd_q.size() && i < 4; i++)
            check_val("wrap_data", 64'(rd_q[i]), 64'(exp_v[i]));
        check_val("wrap_rresp", 64'(last_rresp), 64'd0);

        // Byte strobes merge into the existing word.
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
        do_write(4'd4, 32'h20, 0, 2, 1, 1, 0);
        wbuf[0] = 32'h1234_5678; sbuf[0] = 4'h5;
        do_write(4'd4, 32'h20, 0, 2, 1, 1, 0);
        do_read(4'd4, 32'h20, 0, 2, 1);
        check_val("strb_count", 64'(rd_q.size()), 64'd1);
        if (rd_q.size() > 0) check_val("strb_merge", 64'(rd_q[0]), 64'hFF34_FF78);

        // Early wlast on a two-beat burst, then reserved burst type on read.
        wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hF;
        do_write(4'd6, 32'h40, 1, 2, 1, 1, 0);
        check_val("early_wlast_bresp", 64'(last_bresp), 64'd2);
        do_read(4'd6, 32'h40, 1, 2, 1);
        do_read(4'd7, 32'h10, 3, 2, 3);
        check_val("rsvd_rresp", 64'(last_rresp), 64'd2);

        // Response backpressure.
        for (int k = 0; k < 2; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
        do_write(4'd10, 32'h80, 1, 2, 1, 2, 5);

        // Random traffic.
        for (int t = 0; t < 80; t++) begin
            burst = $urandom_range(0, 3);
            len   = $urandom_range(0, 15);
            if (burst == 2) begin
                r = $urandom_range(0, 3);
                len = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 7 : 15;
            end
            size = ($urandom_range(0, 5) < 4) ? 2 : $urandom_range(0, 3);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 1) == 0) begin
                r  = $urandom_range(0, 9);
                nb = len + 1;
                if (r == 0) nb = len + 2;
                else if (r == 1 && len > 0) nb = len;
                for (int k = 0; k < nb; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'($urandom); end
                do_write(4'($urandom), addr, len, size, burst, nb, $urandom_range(0, 3));
            end else begin
                do_read(4'($urandom), addr, len, size, burst);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi1_sram_slave.md
Name: axi1_sram_slave

Overview:
- AXI v1.0 slave endpoint that sits directly downstream of the axi1_if slave modport and consumes master traffic into an internal word-addressed register array.
- Independent write FSM (AW, W, B channels) and read FSM (AR, R channels), each handling one outstanding burst.
- Supports FIXED, INCR and WRAP bursts of 1 to 16 beats.
- Used as the default memory target in integration benches and as a scratch RAM in small systems.

Parameters:
- NUM_DATA_BITS, 32, data bus width; must be 32 or 64.
- NUM_ADDR_BITS_P, 32, AXI address width.
- NUM_ID_BITS_P, 4, transaction ID width.
- MEM_WORDS_LOG2, 8, log2 of array depth in bus-width words.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous reset, active-high.
- awid awaddr awlen awsize awburst awvalid  in  ID/ADDR/4/3/2/1  write address channel.
- awready  out  1  write address accept.
- wid wdata wstrb wlast wvalid  in  ID/DATA/DATA/8/1/1  write data channel; wid is ignored.
- wready  out  1  write data accept.
- bid bresp bvalid  out  ID/2/1  write response.
- bready  in  1  write response accept.
- arid araddr arlen arsize arburst arvalid  in  ID/ADDR/4/3/2/1  read address channel.
- arready  out  1  read address accept.
- rid rdata rresp rlast rvalid  out  ID/DATA/2/1/1  read data channel.
- rready  in  1  read data accept.
- awlock/awcache/awprot and arlock/arcache/arprot are not ported; the block ignores them.

Behaviour:
Reset:
- Outputs: all outputs are registered and reset to 0.
- Mid-operation: reset forces both FSMs to IDLE, drops every valid and ready within the same cycle, and discards the in-flight burst.
- Array contents are not reset and are retained across reset.

Handshake rules:
- A transfer occurs on a rising edge where valid and ready are both high.
- The slave never deasserts bvalid or rvalid before the matching ready.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE:
  - awready is 1, starting from the first edge after areset deasserts.
  - On the AW handshake, capture id, addr, len, size and burst; clear beat count and error flag; go to W_DATA. awready drops to 0 on the next cycle.
- W_DATA:
  - wready is 1.
  - Each W handshake writes the bytes of wdata enabled by wstrb to the word at the current address, then advances the address.
  - Beats after beat len are accepted but not written, and set the error flag.
  - The wlast handshake goes to W_RESP. wlast on a beat other than len sets the error flag.
- W_RESP:
  - bvalid is 1 and bid equals the captured id.
  - bresp is 2'b10 (SLVERR) if the error flag is set, otherwise 2'b00 (OKAY).
  - The B handshake returns to W_IDLE.

Read FSM (R_IDLE, R_DATA):
- R_IDLE:
  - arready is 1.
  - The AR handshake captures the same fields and goes to R_DATA.
- R_DATA:
  - rvalid is 1 from the cycle after the AR handshake.
  - rdata is the array word at the current address, read combinationally. rid equals the captured id.
  - rlast is 1 on beat len.
  - Each R handshake advances the address. The handshake carrying rlast returns to R_IDLE.
  - Back-to-back bursts have a minimum one-cycle gap of arready.

Address arithmetic:
- Beat size is B = 2^size bytes. Word index is addr[MEM_ADDR+lsb-1:lsb], where lsb = log2(NUM_DATA_BITS/8), modulo array depth, so out-of-range addresses alias.
- FIXED (00): address is unchanged every beat.
- INCR (01): address += B; no 4KB-boundary check.
- WRAP (10): address = start base + ((addr + B) mod ((len+1)*B)), where base = start aligned down to (len+1)*B.
- Reserved (11) is treated as INCR and sets SLVERR.
- Error conditions that set SLVERR (on bresp, or on every rresp beat of the burst):
  - size greater than lsb;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned start address.
- Data is still transferred when these errors occur.

Simultaneous events:
- A write and a read to the same word in the same cycle: rdata returns the old contents; the write is visible on the next cycle.
- Write and read FSMs run fully concurrently.

Test Plan:
- Reset and ready timing: assert areset mid-W_DATA -> all valids and readies drop to 0 asynchronously; awready=1 and arready=1 one edge after release; no B response is issued.
- INCR write/read, 32-bit bus: AW addr=0x10, len=3, size=2, burst=01, data 0xA0..0xA3, wstrb=0xF -> bresp=00, bid=awid. AR of the same burst -> rdata A0,A1,A2,A3, rlast on beat 3 only.
- WRAP read: pre-load words 0x0..0xC with 0..3; AR addr=0x8, len=3, burst=10 -> rdata 2,3,0,1, rresp=00.
- Byte strobes: write 0xFFFFFFFF to 0x20, then 0x12345678 with wstrb=0x5 -> read back 0xFF34FF78.
- Protocol errors: write with len=1 but wlast on beat 0 -> bresp=10, one word written. Read with burst=11 -> every rresp=10.
- Backpressure: hold bready=0 for 5 cycles -> bvalid and bid stable and awready stays 0. Toggle rready randomly -> rdata/rlast stay stable until each handshake, and beat order is preserved.
